rv0_ahb_ram: RTL and testbench
==============================

// Module: rv0_ahb_ram
// PURPOSE
//  AHB-Lite subordinate: single-port RAM model answering imem_if/dmem_if requester traffic of the core.
//  Decodes one address window, commits writes with byte-lane masking, inserts programmable wait states,
//  returns the two-cycle ERROR response for illegal transfers. Sits on the SoC bus/testbench side.
// PARAMETERS
//  ADDR_WIDTH   32           address width
//  DATA_WIDTH   32           data width (32 or 64); STRB_WIDTH=DATA_WIDTH/8 derived localparam
//  MEM_BASE     'h0010_0000  window base byte address (aligned to MEM_SIZE)
//  MEM_SIZE     65536        window size in bytes, power of 2, multiple of STRB_WIDTH
//  WAIT_STATES  0            data-phase wait cycles per OKAY transfer (0..15)
// PORTS
//  clk_i        in   1           clock
//  rst_ni       in   1           synchronous reset, active low
//  hsel_i       in   1           subordinate select
//  haddr_i      in   ADDR_WIDTH  address-phase address
//  htrans_i     in   2           IDLE/BUSY/NONSEQ/SEQ
//  hwrite_i     in   1           1=write
//  hsize_i      in   3           log2 transfer bytes
//  hready_i     in   1           bus HREADY (previous data phase complete)
//  hwdata_i     in   DATA_WIDTH  write data (data phase)
//  hwstrb_i     in   STRB_WIDTH  write byte strobes (data phase)
//  hrdata_o     out  DATA_WIDTH  read data
//  hreadyout_o  out  1           0 = extend data phase
//  hresp_o      out  1           0=OKAY 1=ERROR
// BEHAVIOUR
//  Reset (sync, rst_ni=0 at rising edge): state IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, wait cnt=0.
//   RAM contents not reset. Reset during WAIT/ERR abandons transfer; pending write is NOT committed.
//  Accept address phase iff hsel_i & hready_i & htrans_i[1]; capture addr,write,size into data-phase regs.
//   IDLE/BUSY or hsel_i=0 with hready_i=1 -> next state IDLE (zero-wait OKAY, no side effects).
//  Legality at accept: MEM_BASE<=addr<MEM_BASE+MEM_SIZE, addr aligned to 2**hsize, 2**hsize<=STRB_WIDTH.
//  FSM (evaluated every clk; acceptance possible in any state where hready_i=1):
//   IDLE : hreadyout=1 hresp=0.  accept legal -> WAIT_STATES>0 ? WAIT (cnt=WAIT_STATES-1) : DATA;
//          accept illegal -> ERR1.
//   WAIT : hreadyout=0 hresp=0; cnt==0 -> DATA else cnt-1. hready_i is low here, no new accept.
//   DATA : hreadyout=1 hresp=0; transfer completes this cycle; next per accept rules, else IDLE.
//   ERR1 : hreadyout=0 hresp=1 -> ERR2.   ERR2 : hreadyout=1 hresp=1; next per accept rules, else IDLE.
//  Write commit: at the DATA-state edge; byte i written iff lane_mask[i] & hwstrb_i[i];
//   lane_mask = (2**hsize ones) << addr[log2(STRB_WIDTH)-1:0]; little-endian lanes. ERROR: no write.
//  Read: hrdata_o = RAM[addr_q word] in DATA (all lanes driven), 0 in every other state.
//   Combinational read of the captured address -> a write committed in cycle N is visible to a read
//   data phase in cycle N+1 (back-to-back W->R same word returns new data, no forwarding needed).
//  Word index = (addr_q - MEM_BASE) >> log2(STRB_WIDTH); no wrap: out-of-window always errors.
// STRUCTURE
//  rv0_ahb_pkg: htrans_e (IDLE=0,BUSY=1,NONSEQ=2,SEQ=3), hsize_e (BYTE..DWORD), HRESP_OKAY/ERROR consts,
//   ahb_rsp_state_e {IDLE,WAIT,DATA,ERR1,ERR2}.
//  Sub-module rv0_ahb_lane_mask: (hsize, addr LSBs) -> STRB_WIDTH byte mask + misalign flag.
//  Top holds capture regs, FSM, wait counter, RAM array (logic [DATA_WIDTH-1:0] mem[MEM_SIZE/STRB_WIDTH]).
// TESTING
//  1 WS=0: write WORD 0xDEADBEEF @0x0010_0004, strb=4'hF, then read -> hreadyout=1 both, hrdata=0xDEADBEEF.
//  2 BYTE write hwdata=0x00AB_0000 @0x0010_0006 strb=4'h4; read WORD @0x0010_0004 -> 0xDEABBEEF;
//    repeat with strb=4'h0 -> word unchanged.
//  3 Pipelined: NONSEQ write 0x1234_5678 @0x0010_0008 then NONSEQ read same addr next cycle ->
//    read data phase returns 0x1234_5678, OKAY, no stall.
//  4 Read @0x0000_0000 (out of window) and WORD @0x0010_0002 (misaligned) -> cycle1 hreadyout=0 hresp=1,
//    cycle2 hreadyout=1 hresp=1; following IDLE -> hresp=0; memory unchanged.
//  5 WAIT_STATES=2: read @0x0010_0004 -> hreadyout low exactly 2 cycles, data 0xDEABBEEF on 3rd.
//  6 WAIT_STATES=2: write 0xFFFF_FFFF @0x0010_000C, assert rst_ni=0 in first WAIT cycle -> after
//    release hreadyout=1 hresp=0 hrdata=0; read @0x0010_000C returns prior contents.

Source files
------------

// File: rtl/rv0_ahb_pkg.sv
// Shared AHB-Lite encodings and response-FSM state type for the rv0 bus slice.
package rv0_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_DATA,
    RSP_ERR1,
    RSP_ERR2
  } ahb_rsp_state_e;

endpackage

// File: rtl/rv0_ahb_ram_lane_mask.sv
// Byte-lane enable mask for one AHB transfer plus a flag for transfers that are
// misaligned or wider than the data bus.
module rv0_ahb_lane_mask #(
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned OFF_W      = $clog2(STRB_WIDTH)
) (
  input  logic [2:0]            hsize,
  input  logic [OFF_W-1:0]      addr_lsb,
  output logic [STRB_WIDTH-1:0] lane_mask,
  output logic                  misalign
);

  int unsigned nbytes;
  int unsigned lsb;

  always_comb begin
    nbytes    = 32'd1 << hsize;
    lsb       = 32'(addr_lsb);
    lane_mask = '0;
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      if ((i >= lsb) && (i < lsb + nbytes)) begin
        lane_mask[i] = 1'b1;
      end
    end
    misalign = (nbytes > STRB_WIDTH) || ((lsb & (nbytes - 32'd1)) != 32'd0);
  end

endmodule

// File: rtl/rv0_ahb_ram.sv
// AHB-Lite subordinate RAM: one decoded window, byte-lane writes, programmable
// wait states and the two-cycle ERROR response for illegal transfers.
module rv0_ahb_ram
  import rv0_ahb_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  MEM_BASE    = 'h0010_0000,
  parameter int unsigned            MEM_SIZE    = 65536,
  parameter int unsigned            WAIT_STATES = 0,
  localparam int unsigned           STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic                  hready_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic [STRB_WIDTH-1:0] hwstrb_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hreadyout_o,
  output logic                  hresp_o
);

  localparam int unsigned OFF_W   = $clog2(STRB_WIDTH);
  localparam int unsigned SIZE_W  = $clog2(MEM_SIZE);
  localparam int unsigned IDX_W   = SIZE_W - OFF_W;
  localparam int unsigned WORDS   = MEM_SIZE / STRB_WIDTH;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_rsp_state_e state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [STRB_WIDTH-1:0] mask_q;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  accept;
  logic                  capture;
  logic                  in_window;
  logic                  misalign;
  logic                  legal;
  logic [STRB_WIDTH-1:0] lane_mask;

  rv0_ahb_lane_mask #(
    .STRB_WIDTH (STRB_WIDTH)
  ) u_lane_mask (
    .hsize     (hsize_i),
    .addr_lsb  (haddr_i[OFF_W-1:0]),
    .lane_mask (lane_mask),
    .misalign  (misalign)
  );

  // Base is aligned to the window size, so the window test is an upper-bit compare.
  assign in_window = (haddr_i[ADDR_WIDTH-1:SIZE_W] == MEM_BASE[ADDR_WIDTH-1:SIZE_W]);
  assign legal     = in_window && !misalign;
  assign accept    = hsel_i && hready_i &&
                     ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    capture     = 1'b0;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    unique case (state_q)
      RSP_WAIT: begin
        hreadyout_o = 1'b0;
        if (wait_cnt_q == 4'd0) begin
          state_d = RSP_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RSP_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = RSP_ERR2;
      end
      default: begin
        if (state_q == RSP_ERR2) begin
          hresp_o = HRESP_ERROR;
        end
        if (accept) begin
          capture = 1'b1;
          if (!legal) begin
            state_d = RSP_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = RSP_WAIT;
            wait_cnt_d = WS_LOAD;
          end else begin
            state_d = RSP_DATA;
          end
        end else begin
          state_d = RSP_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RSP_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (capture) begin
        idx_q   <= haddr_i[SIZE_W-1:OFF_W];
        write_q <= hwrite_i;
        mask_q  <= lane_mask;
      end
    end
  end

  // RAM is never cleared; a reset in any state drops the write in flight.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == RSP_DATA) && write_q) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (mask_q[b] && hwstrb_i[b]) begin
          mem[idx_q][b*8 +: 8] <= hwdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    hrdata_o = '0;
    if (state_q == RSP_DATA) begin
      hrdata_o = mem[idx_q];
    end
  end

endmodule

// File: tb/tb_rv0_ahb_ram.sv
// Bench for rv0_ahb_ram: a zero-wait and a two-wait instance on one shared bus,
// table-driven pipelined transfers checked through a scoreboard queue.
module tb_rv0_ahb_ram;
  import rv0_ahb_pkg::*;

  typedef struct {
    int          id;
    bit          sel;        // 0: zero-wait RAM, 1: two-wait RAM
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          err;
    int          waits;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic [31:0] rd0, rd2;
  logic        ro0, ro2, rs0, rs2;

  int total = 0;
  int bad   = 0;

  vec_t vt[$];
  vec_t sb_q[$];
  vec_t cur;
  bit   dp_active = 1'b0;
  bit   mon_en    = 1'b1;
  int   wcnt, ecyc;

  always #5 clk = ~clk;

  assign hready = ro0 & ro2;

  rv0_ahb_ram #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_BASE    (32'h0010_0000),
    .MEM_SIZE    (65536),
    .WAIT_STATES (0)
  ) dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .hsel_i      (hsel0),
    .haddr_i     (haddr),
    .htrans_i    (htrans),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hready_i    (hready),
    .hwdata_i    (hwdata),
    .hwstrb_i    (hwstrb),
    .hrdata_o    (rd0),
    .hreadyout_o (ro0),
    .hresp_o     (rs0)
  );

  rv0_ahb_ram #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_BASE    (32'h0010_0000),
    .MEM_SIZE    (65536),
    .WAIT_STATES (2)
  ) dut2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .hsel_i      (hsel2),
    .haddr_i     (haddr),
    .htrans_i    (htrans),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hready_i    (hready),
    .hwdata_i    (hwdata),
    .hwstrb_i    (hwstrb),
    .hrdata_o    (rd2),
    .hreadyout_o (ro2),
    .hresp_o     (rs2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit sel, logic [31:0] addr, bit wr, logic [2:0] size,
                              logic [31:0] wdata, logic [3:0] strb,
                              logic [31:0] exp_rdata, bit err, int waits);
    vec_t v;
    v.id = 0; v.sel = sel; v.addr = addr; v.write = wr; v.size = size;
    v.wdata = wdata; v.strb = strb; v.exp_rdata = exp_rdata; v.err = err; v.waits = waits;
    return v;
  endfunction

  task automatic bus_idle();
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = HTRANS_IDLE;
  endtask

  // Present one address phase, wait for it to be accepted, then drive its write data.
  task automatic drive(input vec_t v);
    int n;
    bit ok;
    hsel0  = (v.sel == 1'b0);
    hsel2  = (v.sel == 1'b1);
    haddr  = v.addr;
    htrans = HTRANS_NONSEQ;
    hwrite = v.write;
    hsize  = v.size;
    sb_q.push_back(v);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = hready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout v%0d: hready stayed 0 for %0d cycles, expected 1", v.id, n);
    end
    hwdata = v.wdata;
    hwstrb = v.strb;
    bus_idle();
  endtask

  task automatic flush();
    int n;
    bus_idle();
    n = 0;
    while ((dp_active || sb_q.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (dp_active || sb_q.size() != 0) begin
      bad++;
      $display("FAIL flush_timeout: data phase pending=%0d queued=%0d, expected 0", dp_active, sb_q.size());
      dp_active = 1'b0;
      sb_q.delete();
    end
  endtask

  // Scoreboard monitor: checks the data phase in progress, then pops the next accepted transfer.
  always @(negedge clk) begin
    logic        ro, rs;
    logic [31:0] rd;
    bit          done;
    if (mon_en) begin
      if (!rst_n) begin
        dp_active = 1'b0;
      end else begin
        done = 1'b0;
        if (dp_active) begin
          ro = cur.sel ? ro2 : ro0;
          rs = cur.sel ? rs2 : rs0;
          rd = cur.sel ? rd2 : rd0;
          if (cur.err) begin
            check($sformatf("v%0d_err%0d_ready", cur.id, ecyc + 1), {31'd0, ro}, (ecyc == 0) ? 32'd0 : 32'd1);
            check($sformatf("v%0d_err%0d_resp", cur.id, ecyc + 1), {31'd0, rs}, 32'd1);
            done = (ecyc != 0);
            ecyc++;
          end else if (!ro) begin
            check($sformatf("v%0d_stall_resp", cur.id), {31'd0, rs}, 32'd0);
            check($sformatf("v%0d_stall_rdata", cur.id), rd, 32'd0);
            wcnt++;
            if (wcnt > 16) begin
              bad++;
              $display("FAIL v%0d_stall_bound: %0d wait cycles, expected %0d", cur.id, wcnt, cur.waits);
              done = 1'b1;
            end
          end else begin
            check($sformatf("v%0d_resp", cur.id), {31'd0, rs}, 32'd0);
            check($sformatf("v%0d_waits", cur.id), wcnt, cur.waits);
            if (!cur.write) begin
              check($sformatf("v%0d_rdata", cur.id), rd, cur.exp_rdata);
            end
            done = 1'b1;
          end
        end
        if (done) dp_active = 1'b0;
        if ((hsel0 || hsel2) && hready && htrans[1]) begin
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: accepted transfer with empty queue, expected a queued record");
          end else begin
            cur       = sb_q.pop_front();
            dp_active = 1'b1;
            wcnt      = 0;
            ecyc      = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt.push_back(mk(0, 32'h0010_0004, 1, SIZE_WORD,  32'hDEAD_BEEF, 4'hF, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_0004, 0, SIZE_WORD,  32'h0,         4'h0, 32'hDEAD_BEEF, 0, 0));
    vt.push_back(mk(0, 32'h0010_0006, 1, SIZE_BYTE,  32'h00AB_0000, 4'h4, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_0004, 0, SIZE_WORD,  32'h0,         4'h0, 32'hDEAB_BEEF, 0, 0));
    vt.push_back(mk(0, 32'h0010_0006, 1, SIZE_BYTE,  32'h0011_0000, 4'h0, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_0004, 0, SIZE_WORD,  32'h0,         4'h0, 32'hDEAB_BEEF, 0, 0));
    vt.push_back(mk(0, 32'h0010_0008, 1, SIZE_WORD,  32'h1234_5678, 4'hF, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_0008, 0, SIZE_WORD,  32'h0,         4'h0, 32'h1234_5678, 0, 0));
    vt.push_back(mk(0, 32'h0000_0000, 0, SIZE_WORD,  32'h0,         4'h0, 32'h0,         1, 0));
    vt.push_back(mk(0, 32'h0010_0002, 0, SIZE_WORD,  32'h0,         4'h0, 32'h0,         1, 0));
    vt.push_back(mk(0, 32'h0010_0006, 1, SIZE_WORD,  32'hFFFF_FFFF, 4'hF, 32'h0,         1, 0));
    vt.push_back(mk(0, 32'h0010_0004, 0, SIZE_WORD,  32'h0,         4'h0, 32'hDEAB_BEEF, 0, 0));
    vt.push_back(mk(0, 32'h0010_000A, 1, SIZE_HALF,  32'hA5A5_0000, 4'hF, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_0008, 0, SIZE_WORD,  32'h0,         4'h0, 32'hA5A5_5678, 0, 0));
    vt.push_back(mk(0, 32'h0011_0000, 0, SIZE_WORD,  32'h0,         4'h0, 32'h0,         1, 0));
    vt.push_back(mk(0, 32'h0010_FFFC, 1, SIZE_WORD,  32'hCAFE_F00D, 4'hF, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_FFFC, 0, SIZE_WORD,  32'h0,         4'h0, 32'hCAFE_F00D, 0, 0));
    vt.push_back(mk(0, 32'h0010_0008, 0, SIZE_DWORD, 32'h0,         4'h0, 32'h0,         1, 0));
    vt.push_back(mk(0, 32'h0010_0004, 1, SIZE_HALF,  32'h0000_1122, 4'h3, 32'h0,         0, 0));
    vt.push_back(mk(0, 32'h0010_0005, 0, SIZE_BYTE,  32'h0,         4'h0, 32'hDEAB_1122, 0, 0));
    vt.push_back(mk(1, 32'h0010_0004, 1, SIZE_WORD,  32'hDEAB_BEEF, 4'hF, 32'h0,         0, 2));
    vt.push_back(mk(1, 32'h0010_0004, 0, SIZE_WORD,  32'h0,         4'h0, 32'hDEAB_BEEF, 0, 2));
    vt.push_back(mk(1, 32'h0010_000C, 1, SIZE_WORD,  32'h0C0C_0C0C, 4'hF, 32'h0,         0, 2));
    vt.push_back(mk(1, 32'h0010_000C, 0, SIZE_WORD,  32'h0,         4'h0, 32'h0C0C_0C0C, 0, 2));
    foreach (vt[i]) vt[i].id = i;

    rst_n  = 1'b0;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = SIZE_WORD;
    hwdata = '0;
    hwstrb = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, ro0}, 32'd1);
    check("rst_resp0",  {31'd0, rs0}, 32'd0);
    check("rst_rdata0", rd0,          32'd0);
    check("rst_ready2", {31'd0, ro2}, 32'd1);
    check("rst_resp2",  {31'd0, rs2}, 32'd0);
    check("rst_rdata2", rd2,          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
    end
    flush();

    @(negedge clk);
    check("idle_resp0",  {31'd0, rs0}, 32'd0);
    check("idle_ready0", {31'd0, ro0}, 32'd1);
    @(posedge clk); #1;

    // Reset during the first wait cycle of a write must drop the write.
    mon_en = 1'b0;
    hsel2  = 1'b1;
    haddr  = 32'h0010_000C;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = SIZE_WORD;
    @(posedge clk); #1;
    hwdata = 32'hFFFF_FFFF;
    hwstrb = 4'hF;
    bus_idle();
    @(negedge clk);
    check("ws_first_wait_ready", {31'd0, ro2}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready2", {31'd0, ro2}, 32'd1);
    check("post_rst_resp2",  {31'd0, rs2}, 32'd0);
    check("post_rst_rdata2", rd2,          32'd0);
    @(posedge clk); #1;
    dp_active = 1'b0;
    mon_en    = 1'b1;

    drive(mk(1, 32'h0010_000C, 0, SIZE_WORD, 32'h0, 4'h0, 32'h0C0C_0C0C, 0, 2));
    drive(mk(0, 32'h0010_0004, 0, SIZE_WORD, 32'h0, 4'h0, 32'hDEAB_1122, 0, 0));
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
